// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
//   XOR-blits 8-pixel-wide sprites into an on-chip monochrome frame buffer,
//   one whole frame-buffer row per cycle (read-modify-write), and reports
//   pixel collisions on vf. Also clears the frame buffer one row per cycle
//   and offers a combinational scan-out read port.
//
// Configuration macro:
//   SPRITE_WRAP_EN  defined   -> sprites wrap around the right and bottom edges
//                   undefined -> sprites are clipped at the right and bottom edges
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset (forces a full clear)
//   clear_req    clear request, sampled only in IDLE (wins over draw_req)
//   draw_req     draw request, sampled only in IDLE
//   row, col     sprite start row / column (taken modulo DISP_H / DISP_W)
//   height       sprite rows, clamped to MAX_ROWS
//   sprite_data  sprite row i at [8*(MAX_ROWS-i)-1 -: 8], bit7 = leftmost pixel
//   busy         high in any state but IDLE
//   done         one-cycle pulse when a clear or draw completes
//   vf           collision flag of the last draw
//   rd_row       scan-out row select
//   rd_data      frame-buffer row rd_row, bit x = pixel column x
// -----------------------------------------------------------------------------
module sprite_blitter #(
   parameter int DISP_W   = 64,
   parameter int DISP_H   = 32,
   parameter int MAX_ROWS = 15
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear_req,
   input  logic                          draw_req,
   input  logic [7:0]                    row,
   input  logic [7:0]                    col,
   input  logic [$clog2(MAX_ROWS+1)-1:0] height,
   input  logic [8*MAX_ROWS-1:0]         sprite_data,
   output logic                          busy,
   output logic                          done,
   output logic                          vf,
   input  logic [$clog2(DISP_H)-1:0]     rd_row,
   output logic [DISP_W-1:0]             rd_data
);

   localparam int XW = $clog2(DISP_W);
   localparam int YW = $clog2(DISP_H);
   localparam int HW = $clog2(MAX_ROWS+1);
   // One counter serves both the clear (rows) and the draw (sprite rows).
   localparam int CW = (YW > HW) ? YW : HW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_DRAW,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [XW-1:0]           x0_q, x0_d;
   logic [YW-1:0]           y0_q, y0_d;
   logic [HW-1:0]           h_q, h_d;
   logic [8*MAX_ROWS-1:0]   spr_q, spr_d;
   logic                    vf_q, vf_d;

   logic [DISP_W-1:0]       vram_q [DISP_H];

   logic [HW-1:0]           h_clamped;
   logic [7:0]              spr_byte;
   logic [7:0]              spr_rev;
   logic [DISP_W-1:0]       mask;
   logic [YW-1:0]           row_y;
   logic                    row_ok;
   logic                    hit;

   // -------------------------------------------------------------------------
   // Current sprite row -> frame-buffer row index and column mask
   // -------------------------------------------------------------------------
   assign h_clamped = (height > HW'(MAX_ROWS)) ? HW'(MAX_ROWS) : height;

   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      spr_byte = '0;
      for (int i = 0; i < MAX_ROWS; i++) begin
         if (cnt_q == CW'(i)) spr_byte = spr_q[8*(MAX_ROWS-i)-1 -: 8];
      end
      // Pixel k (from the left) lands at column x0+k, i.e. bit x0+k.
      spr_rev = '0;
      for (int k = 0; k < 8; k++) spr_rev[k] = spr_byte[7-k];
   end

`ifdef SPRITE_WRAP_EN
   logic [2*DISP_W-1:0] wide_mask;

   always_comb begin
      // Bits shifted past the right edge fold back onto column 0.
      wide_mask = {{DISP_W{1'b0}}, DISP_W'(spr_rev)} << x0_q;
      mask      = wide_mask[DISP_W-1:0] | wide_mask[2*DISP_W-1:DISP_W];
      row_y     = y0_q + cnt_q[YW-1:0];
      row_ok    = 1'b1;
   end
`else
   logic [CW:0] y_sum;

   always_comb begin
      // Shifting within DISP_W bits discards columns past the right edge.
      mask   = DISP_W'(spr_rev) << x0_q;
      y_sum  = (CW+1)'(y0_q) + (CW+1)'(cnt_q);
      row_ok = (y_sum < (CW+1)'(DISP_H));
      row_y  = y_sum[YW-1:0];
   end
`endif

   assign hit = row_ok && ((vram_q[row_y] & mask) != '0);

   // -------------------------------------------------------------------------
   // FSM next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      h_d     = h_q;
      spr_d   = spr_q;
      vf_d    = vf_q;
      case (state_q)
         S_IDLE: begin
            if (clear_req) begin
               cnt_d   = '0;
               state_d = S_CLEAR;
            end else if (draw_req) begin
               x0_d    = XW'(32'(col) % DISP_W);
               y0_d    = YW'(32'(row) % DISP_H);
               h_d     = h_clamped;
               spr_d   = sprite_data;
               vf_d    = 1'b0;
               cnt_d   = '0;
               state_d = (h_clamped == '0) ? S_DONE : S_DRAW;
            end
         end
         S_CLEAR: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DISP_H-1)) state_d = S_DONE;
         end
         S_DRAW: begin
            if (hit) vf_d = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(h_q) - CW'(1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers; reset lands in CLEAR so the frame buffer gets zeroed
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst_n) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         h_q     <= '0;
         spr_q   <= '0;
         vf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         h_q     <= h_d;
         spr_q   <= spr_d;
         vf_q    <= vf_d;
      end
   end

   // NOTE: the frame buffer has no reset so it can map onto RAM/plain flops;
   // the CLEAR pass that follows every reset zeroes it instead.
   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) begin
         vram_q[cnt_q[YW-1:0]] <= '0;
      end else if (state_q == S_DRAW && row_ok) begin
         vram_q[row_y] <= vram_q[row_y] ^ mask;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign vf      = vf_q;
   assign rd_data = vram_q[rd_row];

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
//   Directed bench for sprite_blitter at 64x32, MAX_ROWS=15. Inputs change and
//   outputs are sampled on the falling clock edge. Expected values are hand
//   computed; SPRITE_WRAP_EN selects the wrap-build expectations.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

   logic         clk;
   logic         rst_n;
   logic         clear_req;
   logic         draw_req;
   logic [7:0]   row;
   logic [7:0]   col;
   logic [3:0]   height;
   logic [119:0] sprite_data;
   logic         busy;
   logic         done;
   logic         vf;
   logic [4:0]   rd_row;
   logic [63:0]  rd_data;

   int total = 0;
   int bad   = 0;

   sprite_blitter #(
      .DISP_W   (64),
      .DISP_H   (32),
      .MAX_ROWS (15)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_req   (clear_req),
      .draw_req    (draw_req),
      .row         (row),
      .col         (col),
      .height      (height),
      .sprite_data (sprite_data),
      .busy        (busy),
      .done        (done),
      .vf          (vf),
      .rd_row      (rd_row),
      .rd_data     (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- helpers
   task automatic read_row(input int r, output logic [63:0] d);
      rd_row = 5'(r);
      #1;
      d = rd_data;
   endtask

   // Called on a falling edge; counts rising edges until done is seen.
   task automatic wait_done(input int start, output int edges);
      edges = start;
      while (!done && edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      if (!done) edges = -1;
   endtask

   // Returns the number of rising edges from the accepting edge to done.
   task automatic issue_draw(input logic [7:0] r, input logic [7:0] c,
                             input logic [3:0] h, input logic [119:0] data,
                             output int edges);
      @(negedge clk);
      row = r; col = c; height = h; sprite_data = data; draw_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      draw_req = 1'b0;
      wait_done(1, edges);
   endtask

   function automatic logic [119:0] spr3(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2);
      logic [119:0] s;
      s = '0;
      s[119:112] = b0;
      s[111:104] = b1;
      s[103:96]  = b2;
      return s;
   endfunction

   // ------------------------------------------------------------------ tests
   task automatic test_reset;
      int          edges;
      logic [63:0] d;
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || vf !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: busy=%b done=%b vf=%b, want busy=1 done=0 vf=0", busy, done, vf);
      end
      rst_n = 1'b1;
      wait_done(0, edges);
      total++;
      if (edges !== 32) begin
         bad++;
         $display("FAIL reset_clear_len: edges=%0d, want 32", edges);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || vf !== 1'b0) begin
         bad++;
         $display("FAIL reset_after_done: busy=%b done=%b vf=%b, want 0 0 0", busy, done, vf);
      end
      for (int r = 0; r < 32; r++) begin
         read_row(r, d);
         total++;
         if (d !== 64'h0) begin
            bad++;
            $display("FAIL reset_row%0d: got %h, want 0", r, d);
         end
      end
   endtask

   task automatic test_draw_basic;
      int          edges;
      logic [63:0] d;
      issue_draw(8'd0, 8'd0, 4'd1, spr3(8'hF0, 8'h00, 8'h00), edges);
      read_row(0, d);
      total++;
      if (edges !== 2 || d !== 64'h0F || vf !== 1'b0) begin
         bad++;
         $display("FAIL draw_basic: edges=%0d row0=%h vf=%b, want 2 000000000000000f 0", edges, d, vf);
      end
      issue_draw(8'd0, 8'd0, 4'd1, spr3(8'hF0, 8'h00, 8'h00), edges);
      read_row(0, d);
      total++;
      if (d !== 64'h0 || vf !== 1'b1) begin
         bad++;
         $display("FAIL draw_collide: row0=%h vf=%b, want 0 1", d, vf);
      end
   endtask

   task automatic test_draw_offset;
      int          edges;
      logic [63:0] d3, d4;
      issue_draw(8'd35, 8'd70, 4'd2, spr3(8'h81, 8'hFF, 8'h00), edges);
      read_row(3, d3);
      read_row(4, d4);
      total++;
      if (edges !== 3) begin
         bad++;
         $display("FAIL offset_latency: edges=%0d, want 3", edges);
      end
      total++;
      if (d3 !== 64'h2040 || d4 !== 64'h3FC0 || vf !== 1'b0) begin
         bad++;
         $display("FAIL offset_rows: row3=%h row4=%h vf=%b, want 2040 3fc0 0", d3, d4, vf);
      end
   endtask

   task automatic test_edge;
      int          edges;
      logic [63:0] d30, d31, d0;
      logic [63:0] exp_r, exp_0;
`ifdef SPRITE_WRAP_EN
      exp_r = 64'hF00000000000000F;
      exp_0 = 64'hF00000000000000F;
`else
      exp_r = 64'hF000000000000000;
      exp_0 = 64'h0;
`endif
      issue_draw(8'd30, 8'd60, 4'd3, spr3(8'hFF, 8'hFF, 8'hFF), edges);
      read_row(30, d30);
      read_row(31, d31);
      read_row(0, d0);
      total++;
      if (edges !== 4 || vf !== 1'b0) begin
         bad++;
         $display("FAIL edge_done: edges=%0d vf=%b, want 4 0", edges, vf);
      end
      total++;
      if (d30 !== exp_r || d31 !== exp_r || d0 !== exp_0) begin
         bad++;
         $display("FAIL edge_rows: r30=%h r31=%h r0=%h, want %h %h %h", d30, d31, d0, exp_r, exp_r, exp_0);
      end
      // Same sprite again erases it and collides.
      issue_draw(8'd30, 8'd60, 4'd3, spr3(8'hFF, 8'hFF, 8'hFF), edges);
      read_row(30, d30);
      read_row(0, d0);
      total++;
      if (vf !== 1'b1 || d30 !== 64'h0 || d0 !== 64'h0) begin
         bad++;
         $display("FAIL edge_erase: vf=%b r30=%h r0=%h, want 1 0 0", vf, d30, d0);
      end
   endtask

   task automatic test_priority;
      int          edges;
      logic [63:0] d;
      // Both requests together: clear wins, draw at row 10 is dropped.
      @(negedge clk);
      row = 8'd10; col = 8'd0; height = 4'd1; sprite_data = spr3(8'hFF, 8'h00, 8'h00);
      clear_req = 1'b1; draw_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_req = 1'b0; draw_req = 1'b0;
      wait_done(1, edges);
      total++;
      if (edges !== 33 || vf !== 1'b1) begin
         bad++;
         $display("FAIL prio_clear: edges=%0d vf=%b, want 33 1", edges, vf);
      end
      for (int r = 0; r < 32; r++) begin
         read_row(r, d);
         total++;
         if (d !== 64'h0) begin
            bad++;
            $display("FAIL prio_row%0d: got %h, want 0", r, d);
         end
      end
      // Draw request pulsed during a clear is ignored.
      @(negedge clk);
      clear_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_req = 1'b0;
      repeat (4) @(negedge clk);
      row = 8'd5; draw_req = 1'b1;
      @(negedge clk);
      draw_req = 1'b0;
      wait_done(6, edges);
      @(negedge clk);
      read_row(5, d);
      total++;
      if (d !== 64'h0 || busy !== 1'b0 || vf !== 1'b1) begin
         bad++;
         $display("FAIL busy_ignore: row5=%h busy=%b vf=%b, want 0 0 1", d, busy, vf);
      end
   endtask

   task automatic test_zero_height;
      int edges;
      issue_draw(8'd2, 8'd2, 4'd0, spr3(8'hFF, 8'hFF, 8'hFF), edges);
      total++;
      if (edges !== 1 || vf !== 1'b0) begin
         bad++;
         $display("FAIL zero_height: edges=%0d vf=%b, want 1 0", edges, vf);
      end
   endtask

   task automatic test_reset_mid_draw;
      int           edges;
      logic [63:0]  d;
      logic [119:0] s;
      s = '1;
      issue_draw(8'd0, 8'd0, 4'd1, s, edges);
      // h=5 over a lit row 0: collision after row 0.
      @(negedge clk);
      row = 8'd0; col = 8'd0; height = 4'd5; sprite_data = s; draw_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      draw_req = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (vf !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre: vf=%b busy=%b, want 1 1", vf, busy);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || vf !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: busy=%b done=%b vf=%b, want 1 0 0", busy, done, vf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_done(0, edges);
      total++;
      if (edges !== 32) begin
         bad++;
         $display("FAIL mid_clear_len: edges=%0d, want 32", edges);
      end
      for (int r = 0; r < 32; r++) begin
         read_row(r, d);
         total++;
         if (d !== 64'h0) begin
            bad++;
            $display("FAIL mid_row%0d: got %h, want 0", r, d);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; clear_req = 1'b0; draw_req = 1'b0;
      row = '0; col = '0; height = '0; sprite_data = '0; rd_row = '0;
      test_reset();
      test_draw_basic();
      test_draw_offset();
      test_edge();
      test_priority();
      test_zero_height();
      test_reset_mid_draw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
